// File: rtl/draw_rect_if.sv
`default_nettype none
// ============================================================================
// Module   : draw_rect_if
// Brief    : Request and screen-writer signal bundle for draw_rect.
// Revision : 1.0 - initial release
// ============================================================================
interface draw_rect_if #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3
);
    logic                    req_valid;
    logic                    req_ready;
    logic [WIDTH-1:0]        x0;
    logic [WIDTH-1:0]        y0;
    logic [WIDTH-1:0]        x1;
    logic [WIDTH-1:0]        y1;
    logic [COLOUR_WIDTH-1:0] colour;
    logic [1:0]              mode;
    logic                    busy;
    logic                    done;
    logic                    screen_start;
    logic [COLOUR_WIDTH-1:0] new_screen_colour;
    logic [WIDTH-1:0]        screen_x_min;
    logic [WIDTH-1:0]        screen_y_min;
    logic [WIDTH-1:0]        screen_x_range;
    logic [WIDTH-1:0]        screen_y_range;
    logic [WIDTH-1:0]        screen_x;
    logic [WIDTH-1:0]        screen_y;
    logic [COLOUR_WIDTH-1:0] old_screen_colour;
    logic                    screen_done;

    modport slave (
        input  req_valid, x0, y0, x1, y1, colour, mode,
        input  screen_x, screen_y, old_screen_colour, screen_done,
        output req_ready, busy, done, screen_start, new_screen_colour,
        output screen_x_min, screen_y_min, screen_x_range, screen_y_range
    );

    modport master (
        output req_valid, x0, y0, x1, y1, colour, mode,
        output screen_x, screen_y, old_screen_colour, screen_done,
        input  req_ready, busy, done, screen_start, new_screen_colour,
        input  screen_x_min, screen_y_min, screen_x_range, screen_y_range
    );
endinterface
`default_nettype wire

// File: rtl/draw_rect.sv
`default_nettype none
// ============================================================================
// Module   : draw_rect
// Brief    : Normalises and clips a rectangle request, hands it to a screen
//            writer and supplies the per-pixel colour.
// Revision : 1.0 - initial release
// ============================================================================
module draw_rect #(
    parameter int WIDTH        = 8,
    parameter int COLOUR_WIDTH = 3,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119
) (
    input  logic        clock,
    input  logic        resetn,
    draw_rect_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CALC   = 3'd1,
        START  = 3'd2,
        DRAW   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam logic [1:0]       c_mode_replace = 2'b00;
    localparam logic [1:0]       c_mode_xor     = 2'b01;
    localparam logic [1:0]       c_mode_checker = 2'b10;
    localparam logic [1:0]       c_mode_noop    = 2'b11;
    localparam logic [WIDTH-1:0] c_x_max        = WIDTH'(X_MAX);
    localparam logic [WIDTH-1:0] c_y_max        = WIDTH'(Y_MAX);

    state_t                  r_state;
    state_t                  w_next;
    logic [WIDTH-1:0]        r_x0, r_y0, r_x1, r_y1;
    logic [COLOUR_WIDTH-1:0] r_colour;
    logic [1:0]              r_mode;
    logic [WIDTH-1:0]        r_x_min, r_y_min, r_x_range, r_y_range;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_start;
    logic                    w_done;
    logic                    w_empty;
    logic [WIDTH-1:0]        w_xmin, w_xmax_raw, w_xmax;
    logic [WIDTH-1:0]        w_ymin, w_ymax_raw, w_ymax;
    logic [COLOUR_WIDTH-1:0] w_colour;
    logic                    w_unused;

    assign w_ready  = resetn && (r_state == IDLE);
    assign w_accept = w_ready && bus.req_valid;

    assign w_xmin     = (r_x0 < r_x1) ? r_x0 : r_x1;
    assign w_xmax_raw = (r_x0 < r_x1) ? r_x1 : r_x0;
    assign w_ymin     = (r_y0 < r_y1) ? r_y0 : r_y1;
    assign w_ymax_raw = (r_y0 < r_y1) ? r_y1 : r_y0;
    assign w_xmax     = (w_xmax_raw > c_x_max) ? c_x_max : w_xmax_raw;
    assign w_ymax     = (w_ymax_raw > c_y_max) ? c_y_max : w_ymax_raw;
    // A request with an origin off-screen never reaches the writer, so clamping
    // the max alone is enough to keep max >= min for everything that is drawn.
    assign w_empty    = (w_xmin > c_x_max) || (w_ymin > c_y_max) ||
                        (r_mode == c_mode_noop);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_x0      <= '0;
            r_y0      <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_colour  <= '0;
            r_mode    <= c_mode_replace;
            r_x_min   <= '0;
            r_y_min   <= '0;
            r_x_range <= '0;
            r_y_range <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_x0     <= bus.x0;
                r_y0     <= bus.y0;
                r_x1     <= bus.x1;
                r_y1     <= bus.y1;
                r_colour <= bus.colour;
                r_mode   <= bus.mode;
            end
            // Outputs change only on the CALC->START edge, so they are stable
            // for the whole time the writer is working.
            if (r_state == CALC && !w_empty) begin
                r_x_min   <= w_xmin;
                r_y_min   <= w_ymin;
                r_x_range <= w_xmax - w_xmin;
                r_y_range <= w_ymax - w_ymin;
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    w_next = w_empty ? FINISH : START;
            START: begin
                w_start = 1'b1;
                w_next  = DRAW;
            end
            DRAW:    if (bus.screen_done) w_next = FINISH;
            FINISH: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_colour = r_colour;
        case (r_mode)
            c_mode_replace: w_colour = r_colour;
            c_mode_xor:     w_colour = r_colour ^ bus.old_screen_colour;
            c_mode_checker: w_colour = (bus.screen_x[0] ^ bus.screen_y[0]) ?
                                       bus.old_screen_colour : r_colour;
            default:        w_colour = bus.old_screen_colour;
        endcase
    end

    // Only the low coordinate bits matter for the checker pattern.
    assign w_unused = &{1'b0, bus.screen_x[WIDTH-1:1], bus.screen_y[WIDTH-1:1]};

    assign bus.req_ready         = w_ready;
    assign bus.busy              = resetn && (r_state != IDLE);
    assign bus.done              = resetn && w_done;
    assign bus.screen_start      = resetn && w_start;
    assign bus.new_screen_colour = w_colour;
    assign bus.screen_x_min      = r_x_min;
    assign bus.screen_y_min      = r_y_min;
    assign bus.screen_x_range    = r_x_range;
    assign bus.screen_y_range    = r_y_range;
endmodule
`default_nettype wire

// File: tb/tb_draw_rect.sv
`default_nettype none
// ============================================================================
// Module   : tb_draw_rect
// Brief    : Directed self-checking bench for draw_rect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_rect;
    logic clock;
    logic resetn;
    int   n_tests = 0;
    int   n_fail  = 0;

    draw_rect_if #(.WIDTH(8), .COLOUR_WIDTH(3)) bus ();

    draw_rect #(
        .WIDTH(8), .COLOUR_WIDTH(3), .X_MAX(159), .Y_MAX(119)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [7:0] x0, input logic [7:0] y0,
                           input logic [7:0] x1, input logic [7:0] y1,
                           input logic [2:0] col, input logic [1:0] md);
        bus.x0 = x0; bus.y0 = y0; bus.x1 = x1; bus.y1 = y1;
        bus.colour = col; bus.mode = md;
        bus.req_valid = 1'b1;
    endtask

    // Called in DRAW: pulse screen_done, expect done next cycle, then IDLE.
    task automatic finish_draw(input string tag);
        bus.screen_done = 1'b1;
        tick();
        bus.screen_done = 1'b0;
        check({tag, "_done"}, bus.done, 1);
        tick();
        check({tag, "_idle_busy"}, bus.busy, 0);
        check({tag, "_idle_done"}, bus.done, 0);
    endtask

    initial begin
        resetn = 1'b0;
        bus.req_valid = 1'b0;
        bus.x0 = '0; bus.y0 = '0; bus.x1 = '0; bus.y1 = '0;
        bus.colour = '0; bus.mode = '0;
        bus.screen_x = '0; bus.screen_y = '0;
        bus.old_screen_colour = '0; bus.screen_done = 1'b0;

        // Reset
        repeat (3) tick();
        check("rst_ready", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_start", bus.screen_start, 0);
        resetn = 1'b1;
        #1;
        check("rst_xmin", bus.screen_x_min, 0);
        check("rst_yrange", bus.screen_y_range, 0);
        check("rst_colour", bus.new_screen_colour, 0);
        check("rst_ready_after", bus.req_ready, 1);

        // Replace, corners given in reverse order
        present(8'd10, 8'd20, 8'd3, 8'd5, 3'b101, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        check("rep_calc_busy", bus.busy, 1);
        check("rep_calc_start", bus.screen_start, 0);
        check("rep_calc_ready", bus.req_ready, 0);
        tick();
        check("rep_start", bus.screen_start, 1);
        check("rep_xmin", bus.screen_x_min, 3);
        check("rep_ymin", bus.screen_y_min, 5);
        check("rep_xrange", bus.screen_x_range, 7);
        check("rep_yrange", bus.screen_y_range, 15);
        check("rep_colour", bus.new_screen_colour, 5);
        tick();
        check("rep_draw_start", bus.screen_start, 0);
        repeat (3) tick();
        check("rep_draw_done", bus.done, 0);
        check("rep_draw_xrange", bus.screen_x_range, 7);
        check("rep_draw_colour", bus.new_screen_colour, 5);
        finish_draw("rep");

        // Clipping
        present(8'd150, 8'd0, 8'd200, 8'd130, 3'b001, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("clip_start", bus.screen_start, 1);
        check("clip_xmin", bus.screen_x_min, 150);
        check("clip_xrange", bus.screen_x_range, 9);
        check("clip_ymin", bus.screen_y_min, 0);
        check("clip_yrange", bus.screen_y_range, 119);
        tick();
        finish_draw("clip");

        // Empty: origin off-screen
        present(8'd170, 8'd10, 8'd170, 8'd20, 3'b001, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        check("empty_calc_start", bus.screen_start, 0);
        tick();
        check("empty_done", bus.done, 1);
        check("empty_start", bus.screen_start, 0);
        check("empty_hold_xmin", bus.screen_x_min, 150);
        tick();
        check("empty_idle", bus.busy, 0);

        // Empty: no-op mode
        bus.old_screen_colour = 3'b100;
        present(8'd1, 8'd1, 8'd5, 8'd5, 3'b010, 2'b11);
        tick();
        bus.req_valid = 1'b0;
        check("noop_calc_start", bus.screen_start, 0);
        check("noop_colour", bus.new_screen_colour, 4);
        tick();
        check("noop_done", bus.done, 1);
        check("noop_start", bus.screen_start, 0);
        tick();
        check("noop_idle", bus.busy, 0);

        // Xor
        present(8'd0, 8'd0, 8'd2, 8'd2, 3'b011, 2'b01);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.old_screen_colour = 3'b110;
        #1;
        check("xor_colour", bus.new_screen_colour, 5);
        finish_draw("xor");

        // Checker
        present(8'd0, 8'd0, 8'd9, 8'd9, 3'b011, 2'b10);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        bus.screen_x = 8'd4; bus.screen_y = 8'd6;
        #1;
        check("chk_even", bus.new_screen_colour, 3);
        bus.screen_x = 8'd5;
        #1;
        check("chk_odd", bus.new_screen_colour, 6);
        finish_draw("chk");

        // Stray screen_done in IDLE
        bus.screen_done = 1'b1;
        tick();
        tick();
        check("stray_busy", bus.busy, 0);
        check("stray_done", bus.done, 0);
        check("stray_ready", bus.req_ready, 1);
        bus.screen_done = 1'b0;

        // req_valid held high; degenerate rectangle, inputs changed while busy
        present(8'd7, 8'd7, 8'd7, 8'd7, 3'b001, 2'b00);
        tick();
        present(8'd20, 8'd30, 8'd10, 8'd40, 3'b010, 2'b00);
        check("hs_calc_ready", bus.req_ready, 0);
        tick();
        check("hs_start", bus.screen_start, 1);
        check("hs_xmin", bus.screen_x_min, 7);
        check("hs_xrange", bus.screen_x_range, 0);
        check("hs_yrange", bus.screen_y_range, 0);
        tick();
        check("hs_draw_ready", bus.req_ready, 0);
        bus.screen_done = 1'b1;
        tick();
        bus.screen_done = 1'b0;
        check("hs_done", bus.done, 1);
        check("hs_finish_ready", bus.req_ready, 0);
        tick();
        check("hs_idle_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("hs_second_busy", bus.busy, 1);
        tick();
        check("hs2_start", bus.screen_start, 1);
        check("hs2_xmin", bus.screen_x_min, 10);
        check("hs2_ymin", bus.screen_y_min, 30);
        check("hs2_xrange", bus.screen_x_range, 10);
        check("hs2_yrange", bus.screen_y_range, 10);
        tick();
        finish_draw("hs2");

        // Reset while in DRAW
        present(8'd1, 8'd2, 8'd3, 8'd4, 3'b111, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("rd_draw_busy", bus.busy, 1);
        resetn = 1'b0;
        tick();
        check("rd_busy", bus.busy, 0);
        check("rd_done", bus.done, 0);
        resetn = 1'b1;
        #1;
        check("rd_ready", bus.req_ready, 1);
        check("rd_xmin_cleared", bus.screen_x_min, 0);
        bus.screen_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rd_no_done", bus.done, 0);
            check("rd_no_start", bus.screen_start, 0);
        end
        bus.screen_done = 1'b0;
        present(8'd4, 8'd3, 8'd2, 8'd2, 3'b110, 2'b00);
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("rd2_start", bus.screen_start, 1);
        check("rd2_xmin", bus.screen_x_min, 2);
        check("rd2_xrange", bus.screen_x_range, 2);
        check("rd2_yrange", bus.screen_y_range, 1);
        tick();
        finish_draw("rd2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/draw_rect.md
DRAW_RECT -- requirements
Module: draw_rect

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 8, coordinate width
- COLOUR_WIDTH, 3, colour width
- X_MAX, 159, largest valid screen x
- Y_MAX, 119, largest valid screen y
REQ-002 Ports SHALL be:
- clock  in  1  single clock; all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- x0, y0, x1, y1  in  WIDTH each  opposite rectangle corners, any order
- colour  in  COLOUR_WIDTH  request colour
- mode  in  2  00 replace, 01 xor, 10 checker, 11 no-op
- busy  out  1  request in progress
- done  out  1  one-cycle completion pulse
- screen_start  out  1  one-cycle start to screen writer
- new_screen_colour  out  COLOUR_WIDTH  colour for the current pixel
- screen_x_min, screen_y_min  out  WIDTH each  rectangle origin
- screen_x_range, screen_y_range  out  WIDTH each  max minus min; inclusive extent is range+1
- screen_x, screen_y  in  WIDTH each  pixel currently addressed by the writer
- old_screen_colour  in  COLOUR_WIDTH  existing colour at screen_x, screen_y
- screen_done  in  1  writer finished the rectangle

Function
REQ-003 The FSM SHALL have the states IDLE, CALC, START, DRAW and FINISH.
REQ-004 req_ready SHALL be 1 only in IDLE with resetn high, and a request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-005 On accept, the block SHALL register x0, y0, x1, y1, colour and mode and move to CALC.
REQ-006 CALC SHALL register xmin=min(x0,x1), xmax=max(x0,x1), and likewise ymin and ymax.
REQ-007 Clipping in CALC: xmax>X_MAX SHALL clamp to X_MAX, and ymax>Y_MAX SHALL clamp to Y_MAX.
REQ-008 The request SHALL be empty if xmin>X_MAX, ymin>Y_MAX, or mode=11.
REQ-009 CALC SHALL go to FINISH if the request is empty, else to START.
REQ-010 START SHALL assert screen_start for exactly one cycle and then go to DRAW.
REQ-011 From START to the cycle after screen_done, screen_x_min=xmin, screen_y_min=ymin, screen_x_range=xmax-xmin and screen_y_range=ymax-ymin, all held stable.
REQ-012 Outside START and DRAW, the min and range outputs SHALL hold their last values.
REQ-013 DRAW SHALL keep screen_start at 0 and move to FINISH on the first cycle screen_done=1.
REQ-014 screen_done SHALL be ignored in every state except DRAW.
REQ-015 new_screen_colour SHALL be combinational from the registered colour and mode, old_screen_colour, screen_x and screen_y, as follows.
- Replace: colour.
- Xor: colour XOR old_screen_colour.
- Checker: colour when screen_x[0] XOR screen_y[0] is 0, else old_screen_colour.
- No-op: old_screen_colour.
REQ-016 FINISH SHALL assert done for one cycle and return to IDLE.
REQ-017 busy SHALL be 1 in CALC, START, DRAW and FINISH, and 0 in IDLE.
REQ-018 Latency: accept at cycle N gives CALC at N+1 and START at N+2.
REQ-019 If screen_done is seen at cycle M, done SHALL be at M+1.
REQ-020 An empty request SHALL produce done at N+2 with no screen_start.
REQ-021 New inputs presented while busy SHALL be ignored and not buffered.
REQ-022 A degenerate rectangle (x0=x1 and/or y0=y1) SHALL be drawn with range 0, not treated as empty.

Reset
REQ-023 With resetn low at a clock edge, the state SHALL become IDLE.
REQ-024 During reset, req_ready, busy, done and screen_start SHALL be 0.
REQ-025 After reset, new_screen_colour and all min and range outputs SHALL be 0.
REQ-026 Reset mid-operation (any state) SHALL abort the request with no done pulse and no further screen_start.

Verification
REQ-027 Replace: x0=10, y0=20, x1=3, y1=5, colour=3'b101, mode=00 -> screen_start at N+2 with min=(3,5) and range=(7,15); done one cycle after screen_done; new_screen_colour=101 throughout.
REQ-028 Clip: x0=150, x1=200, y0=0, y1=130 -> x_min=150, x_range=9, y_min=0, y_range=119.
REQ-029 Empty: x0=x1=170 -> no screen_start, done at N+2; separately mode=11 -> same result.
REQ-030 Xor and checker: colour=011, old=110 -> xor output 101; checker at (4,6) -> 011, at (5,6) -> 110.
REQ-031 Handshake: req_valid held high through a request -> second accept only in IDLE after done; a stray screen_done in IDLE -> no effect.
REQ-032 Reset in DRAW -> next cycle IDLE, busy=0, done never pulses; a following request completes normally.
